quad_encoder_gen: RTL
=====================

QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

Interface
REQ-001 Parameter: PERIOD_WIDTH, default 16, width of quarter-step period input.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  1 = generate steps; 0 = freeze outputs.
REQ-005 dir  input  1  1 = forward (A leads B), 0 = reverse (B leads A).
REQ-006 period  input  PERIOD_WIDTH  clocks per quarter-step (one 4x pulse).
REQ-007 pulses_per_rev_bits  input  5  log2 of 4x pulses per revolution.
REQ-008 sync_clear  input  1  synchronous clear of position and counter.
REQ-009 A, B, Z  output  1 each  registered quadrature and index outputs.
REQ-010 position  output  32  angular position in 4x pulses, 0..2^pulses_per_rev_bits-1.
REQ-011 counter  output  32  signed two's-complement net step count.

Function
REQ-012 Divider counts 0..period-1 while enable=1; terminal count issues one step and returns divider to 0.
REQ-013 period=0 issues no steps; divider held at 0.
REQ-014 Step latency: A/B/position/counter update on the clock edge at which the divider hits terminal count; no additional pipeline.
REQ-015 Phase FSM states S0(A=0,B=0), S1(A=1,B=0), S2(A=1,B=1), S3(A=0,B=1).
REQ-016 Forward step: S0->S1->S2->S3->S0; reverse step: S0->S3->S2->S1->S0; exactly one of A/B toggles per step.
REQ-017 dir sampled only on step edges; dir change mid-period takes effect at next step with no glitch or skipped state.
REQ-018 Forward step: position+1, wrapping (2^n-1)->0; counter+1.
REQ-019 Reverse step: position-1, wrapping 0->(2^n-1); counter-1.
REQ-020 Effective n = pulses_per_rev_bits clamped to range 2..31; position masked to n bits every cycle, so a reduced n takes effect immediately.
REQ-021 counter wraps at 32 bits (0x7FFFFFFF+1 = 0x80000000) with no saturation.
REQ-022 Z=1 exactly while position==0 (one quarter-step wide per revolution, both directions).
REQ-023 enable=0: divider cleared to 0, A/B/Z/position/counter hold.
REQ-024 sync_clear=1: position=0, counter=0, divider=0 on that edge; FSM state (A/B) unchanged; clear wins over a coincident step.
REQ-025 period changed mid-count: new value compared immediately; if divider >= new period-1, step fires on the next edge.

Reset
REQ-026 rst_n=0 asynchronously forces A=0, B=0, FSM=S0, divider=0, position=0, counter=0, Z=0.
REQ-027 Z resumes per REQ-022 from the first clock edge after reset release; first step occurs no earlier than period clocks after release.
REQ-028 Reset asserted mid-step aborts the step; no partial state survives.

Configuration
REQ-029 Macro QUAD_ENCODER_GEN_INDEX_EN: when defined, Z generated per REQ-022.
REQ-030 When QUAD_ENCODER_GEN_INDEX_EN undefined, Z tied to 0 and its comparison logic absent; A/B/position/counter behaviour identical.

Verification
REQ-031 period=5, dir=1, n=12, enable=1 from reset: A rises at clock 5, B at 10, A falls at 15, B falls at 20; position=4, counter=4 after 20 clocks.
REQ-032 n=4, dir=1, 16 steps from position 0: position 15->0 wrap at step 16, Z high for exactly 5 clocks (period=5) at start and at wrap.
REQ-033 From position 0 with dir=0, one step: position=15 (n=4), counter=0xFFFFFFFF, state S3 (A=0,B=1).
REQ-034 dir toggled 1->0 mid-period at state S2: next step goes S2->S1, no A/B glitch, counter decrements.
REQ-035 sync_clear on the same edge as a step at position 7: position=0, counter=0, A/B unchanged; Z=1 next cycle.
REQ-036 rst_n pulsed low mid-period at position 9: all outputs 0 immediately (asynchronous), first step period clocks after release.

Source files
------------

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder pulse generator: period divider, 4-state A/B phase FSM, position and net step count.
// Optional index output Z is built only when QUAD_ENCODER_GEN_INDEX_EN is defined.
module quad_encoder_gen #(
   parameter int PERIOD_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    dir,
   input  logic [PERIOD_WIDTH-1:0] period,
   input  logic [4:0]              pulses_per_rev_bits,
   input  logic                    sync_clear,
   output logic                    A,
   output logic                    B,
   output logic                    Z,
   output logic [31:0]             position,
   output logic [31:0]             counter
);

   // State encoding is {A,B} so the outputs come straight from flops.
   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b10,
      S2 = 2'b11,
      S3 = 2'b01
   } state_t;

   state_t                  r_state, w_state_next;
   logic [PERIOD_WIDTH-1:0] r_div, w_div_next;
   logic [31:0]             r_pos, w_pos_next;
   logic [31:0]             r_cnt, w_cnt_next;
   logic [31:0]             w_mask;
   logic [4:0]              w_n;
   logic                    w_step;

   // A 5-bit input cannot exceed 31, so only the lower bound needs clamping.
   assign w_n    = (pulses_per_rev_bits < 5'd2) ? 5'd2 : pulses_per_rev_bits;
   assign w_mask = (32'd1 << w_n) - 32'd1;
   assign w_step = enable && (period != '0) && (r_div >= period - PERIOD_WIDTH'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S0;
         r_div   <= '0;
         r_pos   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_div   <= w_div_next;
         r_pos   <= w_pos_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_div_next   = r_div;
      w_pos_next   = r_pos & w_mask;
      w_cnt_next   = r_cnt;
      if (sync_clear) begin
         w_div_next = '0;
         w_pos_next = '0;
         w_cnt_next = '0;
      end else if (!enable || period == '0) begin
         w_div_next = '0;
      end else if (w_step) begin
         w_div_next = '0;
         if (dir) begin
            w_pos_next = (r_pos + 32'd1) & w_mask;
            w_cnt_next = r_cnt + 32'd1;
            unique case (r_state)
               S0:      w_state_next = S1;
               S1:      w_state_next = S2;
               S2:      w_state_next = S3;
               default: w_state_next = S0;
            endcase
         end else begin
            w_pos_next = (r_pos - 32'd1) & w_mask;
            w_cnt_next = r_cnt - 32'd1;
            unique case (r_state)
               S0:      w_state_next = S3;
               S3:      w_state_next = S2;
               S2:      w_state_next = S1;
               default: w_state_next = S0;
            endcase
         end
      end else begin
         w_div_next = r_div + PERIOD_WIDTH'(1);
      end
   end

`ifdef QUAD_ENCODER_GEN_INDEX_EN
   logic r_z;

   // Z tracks the registered position exactly, so it is derived from the next value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_z <= 1'b0;
      else        r_z <= (w_pos_next == 32'd0);
   end

   assign Z = r_z;
`else
   assign Z = 1'b0;
`endif

   assign A        = r_state[1];
   assign B        = r_state[0];
   assign position = r_pos;
   assign counter  = r_cnt;

endmodule
